// File: rtl/piso_serializer_if.sv
// Load/serial-stream bundle for piso_serializer.
// The upstream side (master) offers words and watches the serial stream;
// the serializer side (slave) accepts words and drives the stream.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] PI;
    logic             LD_VALID;
    logic             LD_READY;
    logic             SO;
    logic             SO_VALID;
    logic             SO_LAST;
    logic             BUSY;

    modport master (
        output PI,
        output LD_VALID,
        input  LD_READY,
        input  SO,
        input  SO_VALID,
        input  SO_LAST,
        input  BUSY
    );

    modport slave (
        input  PI,
        input  LD_VALID,
        output LD_READY,
        output SO,
        output SO_VALID,
        output SO_LAST,
        output BUSY
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter.
// A word accepted over the valid/ready load handshake is shifted out one bit
// per clock, MSB or LSB first. A new word may be accepted on the edge that
// ends the last bit, giving a gapless stream. All outputs come from state and
// registers only, so PI/LD_VALID never reach an output combinationally.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic C,
    input  logic CLR_N,
    piso_serializer_if.slave link
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [CW-1:0]    count_reg, count_next;

    logic [WIDTH-1:0] shifted;
    logic             out_bit;
    logic             at_last;
    logic             ready;
    logic             load;
    logic             so;
    logic             so_valid;
    logic             busy;

    // Shift direction and output tap depend only on the bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg_reg[WIDTH-2:0], 1'b0};
            assign out_bit = sreg_reg[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {1'b0, sreg_reg[WIDTH-1:1]};
            assign out_bit = sreg_reg[0];
        end
    endgenerate

    // State, shift register and bit counter; reset abandons any word at once.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic and registered-only outputs.
    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        count_next = count_reg;
        so         = IDLE_LEVEL;
        so_valid   = 1'b0;
        busy       = 1'b0;
        at_last    = 1'b0;
        ready      = 1'b0;
        load       = 1'b0;

        if (state_reg == SHIFT) begin
            so       = out_bit;
            so_valid = 1'b1;
            busy     = 1'b1;
            at_last  = (count_reg == LAST_COUNT);
        end

        // Ready while idle, or during the last bit so the next word can follow
        // without a gap.
        ready = (state_reg == IDLE) || at_last;
        load  = link.LD_VALID && ready;

        if (load) begin
            state_next = SHIFT;
            sreg_next  = link.PI;
            count_next = '0;
        end else if (state_reg == SHIFT) begin
            sreg_next = shifted;
            if (at_last) begin
                state_next = IDLE;
                count_next = '0;
            end else begin
                count_next = count_reg + CW'(1);
            end
        end
    end

    assign link.SO       = so;
    assign link.SO_VALID = so_valid;
    assign link.SO_LAST  = at_last;
    assign link.LD_READY = ready;
    assign link.BUSY     = busy;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an 8-bit MSB-first instance feeding a
// small SIPO model, plus a 4-bit LSB-first instance.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n4 = 1'b0;
    int   total = 0;
    int   bad = 0;

    piso_serializer_if #(.WIDTH(8)) bus8 ();
    piso_serializer_if #(.WIDTH(4)) bus4 ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .C(clk), .CLR_N(rst_n), .link(bus8.slave)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4 (
        .C(clk), .CLR_N(rst_n4), .link(bus4.slave)
    );

    always #5 clk = ~clk;

    // Downstream SIPO: shifts SO in every clock, MSB ends up at the top.
    logic [7:0] sipo;
    always @(posedge clk) sipo <= {sipo[6:0], bus8.SO};

    // Observed output vector: {SO, SO_VALID, SO_LAST, LD_READY, BUSY}
    function automatic logic [4:0] obs8();
        return {bus8.SO, bus8.SO_VALID, bus8.SO_LAST, bus8.LD_READY, bus8.BUSY};
    endfunction

    function automatic logic [4:0] obs4();
        return {bus4.SO, bus4.SO_VALID, bus4.SO_LAST, bus4.LD_READY, bus4.BUSY};
    endfunction

    localparam logic [4:0] IDLE_OBS = 5'b00010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word on the 8-bit instance for one edge; returns in word cycle 0.
    task automatic load8(input logic [7:0] w);
        bus8.PI = w;
        bus8.LD_VALID = 1'b1;
        tick();
        bus8.LD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus8.PI = 8'($urandom);
            bus8.LD_VALID = 1'($urandom);
            tick();
            got = obs8();
            total++;
            if (got !== IDLE_OBS) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, got, IDLE_OBS);
            end
        end
        bus8.LD_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset hold done, released");
        // Asynchronous pulse between clock edges during a word
        load8(8'hA5);
        tick();
        tick();
        got = obs8();
        total++;
        if (got[3] !== 1'b1) begin
            bad++;
            $display("FAIL pre_pulse_valid got=%b want=1", got[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL async_pulse got=%b want=%b", got, IDLE_OBS);
        end
        #1 rst_n = 1'b1;
        tick();
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL after_pulse got=%b want=%b", got, IDLE_OBS);
        end
        $display("async reset pulse checked");
    endtask

    task automatic test_single_msb();
        logic [7:0] w = 8'hA5;
        logic [4:0] got, exp;
        load8(w);
        for (int i = 0; i < 8; i++) begin
            exp = {w[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single bit=%0d got=%b want=%b", i, got, exp);
            end
            tick();
        end
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL single_end got=%b want=%b", got, IDLE_OBS);
        end
        total++;
        if (sipo !== 8'hA5) begin
            bad++;
            $display("FAIL sipo_po got=%h want=a5", sipo);
        end
        $display("single word A5 sent, sipo=%h", sipo);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat = 16'hF00F;
        logic [4:0]  got, exp;
        logic        last;
        bus8.PI = 8'hF0;
        bus8.LD_VALID = 1'b1;
        tick();
        bus8.PI = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            last = (i == 7) || (i == 15);
            exp = {pat[15-i], 1'b1, last, last, 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%b want=%b", i, got, exp);
            end
            if (i == 8) bus8.LD_VALID = 1'b0;
            tick();
        end
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL b2b_end got=%b want=%b", got, IDLE_OBS);
        end
        $display("back-to-back F0,0F streamed");
    endtask

    task automatic test_backpressure();
        logic [7:0] w = 8'h96;
        logic [4:0] got, exp;
        load8(w);
        for (int i = 0; i < 8; i++) begin
            exp = {w[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL bp_first bit=%0d got=%b want=%b", i, got, exp);
            end
            if (i == 3) begin
                bus8.PI = 8'h3C;
                bus8.LD_VALID = 1'b1;
            end
            if (i == 5) bus8.PI = 8'hFF;
            tick();
        end
        bus8.LD_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, (i == 7), (i == 7), 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL bp_second bit=%0d got=%b want=%b", i, got, exp);
            end
            tick();
        end
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL bp_end got=%b want=%b", got, IDLE_OBS);
        end
        $display("backpressure: 96 then FF sent");
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'h81;
        logic [4:0] got, exp;
        load8(8'hFF);
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_pre bit=%0d got=%b want=%b", i, got, exp);
            end
            tick();
        end
        #1 rst_n = 1'b0;
        #1;
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL mid_reset got=%b want=%b", got, IDLE_OBS);
        end
        #1 rst_n = 1'b1;
        tick();
        load8(w);
        for (int i = 0; i < 8; i++) begin
            exp = {w[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
            got = obs8();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_after bit=%0d got=%b want=%b", i, got, exp);
            end
            tick();
        end
        got = obs8();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL mid_end got=%b want=%b", got, IDLE_OBS);
        end
        $display("reset mid-word then 81 sent");
    endtask

    task automatic test_lsb_first();
        logic [3:0] w = 4'b0011;
        logic [4:0] got, exp;
        got = obs4();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL lsb_reset got=%b want=%b", got, IDLE_OBS);
        end
        @(negedge clk);
        rst_n4 = 1'b1;
        tick();
        bus4.PI = w;
        bus4.LD_VALID = 1'b1;
        tick();
        bus4.LD_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {w[i], 1'b1, (i == 3), (i == 3), 1'b1};
            got = obs4();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL lsb bit=%0d got=%b want=%b", i, got, exp);
            end
            tick();
        end
        got = obs4();
        total++;
        if (got !== IDLE_OBS) begin
            bad++;
            $display("FAIL lsb_end got=%b want=%b", got, IDLE_OBS);
        end
        $display("lsb-first 0011 sent");
    endtask

    initial begin
        bus8.PI = '0;
        bus8.LD_VALID = 1'b0;
        bus4.PI = '0;
        bus4.LD_VALID = 1'b0;
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
